// File: rtl/nand_sweep_pkg.sv
// Shared definitions for the NAND sweep controller: FSM encoding, reference
// truth tables and a small width helper.
package nand_sweep_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned VEC_W   = 2;
    localparam int unsigned TRUTH_W = 4;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_DRIVE  = 3'd1;
    localparam state_t ST_SETTLE = 3'd2;
    localparam state_t ST_SAMPLE = 3'd3;
    localparam state_t ST_DONE   = 3'd4;

    // Expected Y indexed by {A,B}
    localparam logic [TRUTH_W-1:0] TRUTH_NAND = 4'b0111;
    localparam logic [TRUTH_W-1:0] TRUTH_AND  = 4'b1000;
    localparam logic [TRUTH_W-1:0] TRUTH_OR   = 4'b1110;
    localparam logic [TRUTH_W-1:0] TRUTH_XOR  = 4'b0110;

    // Bits needed to hold values 0..max_value (at least one bit)
    function automatic int unsigned width_for(input int unsigned max_value);
        if (max_value < 2) return 1;
        return $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/nand_sweep_ctrl_settle_timer.sv
// Load/decrement settle counter; last_c flags the final settle cycle.
module settle_timer
    import nand_sweep_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic last_c
);

    localparam int unsigned CNT_W = width_for(SETTLE_CYCLES);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(SETTLE_CYCLES);
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign last_c = (count == CNT_W'(1));

endmodule

// File: rtl/nand_sweep_ctrl.sv
// Sweeps a 2-input gate through all input vectors, compares Y against a
// latched truth table and reports error statistics via start/busy/done.
module nand_sweep_ctrl
    import nand_sweep_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned LOOPS         = 1,
    parameter int unsigned ERR_W         = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [3:0]         truth,
    output logic               drive_a,
    output logic               drive_b,
    input  logic               gate_y,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_cnt,
    output logic [3:0]         err_mask,
    output logic [1:0]         first_err_vec
);

    localparam int unsigned LOOP_W = width_for(LOOPS - 1);
    localparam logic [LOOP_W-1:0] LOOP_LAST = LOOP_W'(LOOPS - 1);

    state_t state;
    state_t next_state;

    logic [TRUTH_W-1:0] truth_q;
    logic [VEC_W-1:0]   vec;
    logic [LOOP_W-1:0]  loop_idx;
    logic               first_seen;

    logic [TRUTH_W-1:0] truth_nxt;
    logic [VEC_W-1:0]   vec_nxt;
    logic [LOOP_W-1:0]  loop_nxt;
    logic               first_seen_nxt;
    logic               drive_a_nxt;
    logic               drive_b_nxt;
    logic               busy_nxt;
    logic               done_nxt;
    logic               pass_nxt;
    logic [ERR_W-1:0]   err_cnt_nxt;
    logic [3:0]         err_mask_nxt;
    logic [1:0]         first_err_vec_nxt;

    logic settle_last_c;
    logic mismatch_c;
    logic last_vec_c;
    logic accept_c;

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (state == ST_DRIVE),
        .dec    (state == ST_SETTLE),
        .last_c (settle_last_c)
    );

    assign mismatch_c = (gate_y != truth_q[vec]);
    assign last_vec_c = (vec == 2'd3) && (loop_idx == LOOP_LAST);
    assign accept_c   = start && !abort;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; abort overrides every non-idle transition
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (accept_c) next_state = ST_DRIVE;
            ST_DRIVE:  next_state = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;
            ST_SETTLE: if (settle_last_c) next_state = ST_SAMPLE;
            ST_SAMPLE: next_state = last_vec_c ? ST_DONE : ST_DRIVE;
            ST_DONE:   next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
        if (abort && (state != ST_IDLE)) begin
            next_state = ST_IDLE;
        end
    end

    // Output / datapath next values
    always_comb begin
        truth_nxt         = truth_q;
        vec_nxt           = vec;
        loop_nxt          = loop_idx;
        first_seen_nxt    = first_seen;
        drive_a_nxt       = drive_a;
        drive_b_nxt       = drive_b;
        busy_nxt          = (next_state != ST_IDLE);
        done_nxt          = 1'b0;
        pass_nxt          = pass;
        err_cnt_nxt       = err_cnt;
        err_mask_nxt      = err_mask;
        first_err_vec_nxt = first_err_vec;

        case (state)
            ST_IDLE: begin
                if (accept_c) begin
                    truth_nxt         = truth;
                    vec_nxt           = '0;
                    loop_nxt          = '0;
                    first_seen_nxt    = 1'b0;
                    pass_nxt          = 1'b0;
                    err_cnt_nxt       = '0;
                    err_mask_nxt      = '0;
                    first_err_vec_nxt = '0;
                end
            end
            ST_DRIVE: begin
                {drive_a_nxt, drive_b_nxt} = vec;
            end
            ST_SAMPLE: begin
                // A sample coinciding with abort is thrown away
                if (!abort) begin
                    if (mismatch_c) begin
                        if (err_cnt != '1) err_cnt_nxt = err_cnt + ERR_W'(1);
                        err_mask_nxt[vec] = 1'b1;
                        if (!first_seen) begin
                            first_err_vec_nxt = vec;
                            first_seen_nxt    = 1'b1;
                        end
                    end
                    if (vec == 2'd3) begin
                        vec_nxt = '0;
                        if (!last_vec_c) loop_nxt = loop_idx + LOOP_W'(1);
                    end else begin
                        vec_nxt = vec + 2'd1;
                    end
                    if (last_vec_c) begin
                        done_nxt = 1'b1;
                        pass_nxt = (err_cnt_nxt == '0);
                    end
                end
            end
            default: ;
        endcase

        if (abort && (state != ST_IDLE)) begin
            drive_a_nxt = 1'b0;
            drive_b_nxt = 1'b0;
            pass_nxt    = 1'b0;
        end
    end

    // Registered outputs and run context
    always_ff @(posedge clk) begin
        if (rst) begin
            truth_q       <= '0;
            vec           <= '0;
            loop_idx      <= '0;
            first_seen    <= 1'b0;
            drive_a       <= 1'b0;
            drive_b       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_cnt       <= '0;
            err_mask      <= '0;
            first_err_vec <= '0;
        end else begin
            truth_q       <= truth_nxt;
            vec           <= vec_nxt;
            loop_idx      <= loop_nxt;
            first_seen    <= first_seen_nxt;
            drive_a       <= drive_a_nxt;
            drive_b       <= drive_b_nxt;
            busy          <= busy_nxt;
            done          <= done_nxt;
            pass          <= pass_nxt;
            err_cnt       <= err_cnt_nxt;
            err_mask      <= err_mask_nxt;
            first_err_vec <= first_err_vec_nxt;
        end
    end

endmodule

// File: tb/tb_nand_sweep_ctrl.sv
// Directed bench for nand_sweep_ctrl: a real NAND instance (1 loop) and a
// stuck-at-1 gate instance (3 loops, narrow error counter).
module tb_nand_sweep_ctrl;
    import nand_sweep_pkg::*;

    logic       clk;
    logic       rst;
    logic       start, abort;
    logic [3:0] truth;
    logic       drive_a, drive_b, gate_y;
    logic       busy, done, pass;
    logic [3:0] err_cnt;
    logic [3:0] err_mask;
    logic [1:0] first_err_vec;

    logic       start3, abort3;
    logic [3:0] truth3;
    logic       drive_a3, drive_b3, gate_y3;
    logic       busy3, done3, pass3;
    logic [2:0] err_cnt3;
    logic [3:0] err_mask3;
    logic [1:0] first_err_vec3;

    int total = 0;
    int bad   = 0;
    int edges = 0;
    logic [1:0] trace [0:127];

    assign gate_y  = ~(drive_a & drive_b);
    assign gate_y3 = 1'b1;

    nand_sweep_ctrl #(.SETTLE_CYCLES(2), .LOOPS(1), .ERR_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .truth(truth),
        .drive_a(drive_a), .drive_b(drive_b), .gate_y(gate_y),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .err_mask(err_mask), .first_err_vec(first_err_vec)
    );

    nand_sweep_ctrl #(.SETTLE_CYCLES(2), .LOOPS(3), .ERR_W(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .abort(abort3), .truth(truth3),
        .drive_a(drive_a3), .drive_b(drive_b3), .gate_y(gate_y3),
        .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err_cnt3),
        .err_mask(err_mask3), .first_err_vec(first_err_vec3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until done (of the selected DUT) or the budget expires
    task automatic wait_done(input bit sel, input int budget);
        bit got;
        got = 1'b0;
        while (!got && (edges < budget)) begin
            tick();
            edges++;
            if (edges < 128) trace[edges] = sel ? {drive_a3, drive_b3} : {drive_a, drive_b};
            got = sel ? done3 : done;
        end
        chk("done_within_budget", 32'(got), 32'd1);
    endtask

    task automatic start_run(input logic [3:0] t);
        truth = t;
        start = 1'b1;
        tick();
        start = 1'b0;
        edges = 0;
    endtask

    initial begin
        bit seen;
        clk = 1'b0; rst = 1'b1; start = 1'b1; abort = 1'b0; truth = TRUTH_NAND;
        start3 = 1'b0; abort3 = 1'b0; truth3 = TRUTH_NAND;

        // Reset held two edges with start pulsed
        tick(); tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_err_mask", 32'(err_mask), 32'd0);
        chk("rst_first", 32'(first_err_vec), 32'd0);
        chk("rst_drive", 32'({drive_a, drive_b}), 32'd0);
        rst = 1'b0; start = 1'b0;
        tick();
        chk("start_in_rst_ignored", 32'(busy), 32'd0);

        // Good NAND run
        start_run(TRUTH_NAND);
        chk("nand_busy", 32'(busy), 32'd1);
        wait_done(1'b0, 40);
        chk("nand_edges", 32'(edges), 32'd16);
        chk("nand_pass", 32'(pass), 32'd1);
        chk("nand_err_cnt", 32'(err_cnt), 32'd0);
        chk("nand_err_mask", 32'(err_mask), 32'd0);
        chk("nand_vec0", 32'(trace[2]), 32'd0);
        chk("nand_vec1", 32'(trace[6]), 32'd1);
        chk("nand_vec2", 32'(trace[10]), 32'd2);
        chk("nand_vec3", 32'(trace[14]), 32'd3);
        tick();
        chk("nand_done_pulse", 32'(done), 32'd0);
        chk("nand_idle", 32'(busy), 32'd0);
        chk("nand_pass_hold", 32'(pass), 32'd1);
        chk("nand_drive_hold", 32'({drive_a, drive_b}), 32'd3);

        // AND table against a NAND: every vector fails
        start_run(TRUTH_AND);
        wait_done(1'b0, 40);
        chk("and_edges", 32'(edges), 32'd16);
        chk("and_err_cnt", 32'(err_cnt), 32'd4);
        chk("and_err_mask", 32'(err_mask), 32'hF);
        chk("and_first", 32'(first_err_vec), 32'd0);
        chk("and_pass", 32'(pass), 32'd0);
        tick();

        // abort beats start in IDLE
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("abort_over_start", 32'(busy), 32'd0);

        // Stuck-at-1 gate, three loops: only vector 11 fails
        truth3 = TRUTH_NAND; start3 = 1'b1;
        tick();
        start3 = 1'b0; edges = 0;
        wait_done(1'b1, 120);
        chk("stuck_edges", 32'(edges), 32'd48);
        chk("stuck_err_cnt", 32'(err_cnt3), 32'd3);
        chk("stuck_err_mask", 32'(err_mask3), 32'h8);
        chk("stuck_first", 32'(first_err_vec3), 32'd3);
        chk("stuck_pass", 32'(pass3), 32'd0);
        tick();

        // Twelve mismatches saturate a 3-bit counter at 7
        truth3 = 4'b0000; start3 = 1'b1;
        tick();
        start3 = 1'b0; edges = 0;
        wait_done(1'b1, 120);
        chk("sat_err_cnt", 32'(err_cnt3), 32'd7);
        chk("sat_err_mask", 32'(err_mask3), 32'hF);
        chk("sat_first", 32'(first_err_vec3), 32'd0);
        tick();

        // start while busy does not restart or stretch the run
        start_run(TRUTH_NAND);
        start = 1'b1;
        for (int i = 0; i < 6; i++) begin tick(); edges++; end
        start = 1'b0;
        wait_done(1'b0, 40);
        chk("busy_start_edges", 32'(edges), 32'd16);
        chk("busy_start_pass", 32'(pass), 32'd1);
        tick();

        // Abort in SETTLE of vector 2
        start_run(TRUTH_AND);
        for (int i = 0; i < 9; i++) begin tick(); edges++; end
        chk("pre_abort_err_cnt", 32'(err_cnt), 32'd2);
        chk("pre_abort_drive", 32'({drive_a, drive_b}), 32'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_drive", 32'({drive_a, drive_b}), 32'd0);
        chk("abort_pass", 32'(pass), 32'd0);
        chk("abort_err_cnt", 32'(err_cnt), 32'd2);
        chk("abort_err_mask", 32'(err_mask), 32'h3);
        chk("abort_first", 32'(first_err_vec), 32'd0);
        seen = done;
        for (int i = 0; i < 20; i++) begin tick(); seen = seen | done; end
        chk("abort_no_done", 32'(seen), 32'd0);

        // Reset during SAMPLE of vector 1
        start_run(TRUTH_AND);
        for (int i = 0; i < 7; i++) begin tick(); edges++; end
        chk("pre_rst_err_cnt", 32'(err_cnt), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_err_cnt", 32'(err_cnt), 32'd0);
        chk("midrst_err_mask", 32'(err_mask), 32'd0);
        chk("midrst_drive", 32'({drive_a, drive_b}), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);

        // Fresh run; truth changed after acceptance must not matter
        start_run(TRUTH_NAND);
        truth = TRUTH_AND;
        wait_done(1'b0, 40);
        chk("post_rst_edges", 32'(edges), 32'd16);
        chk("post_rst_pass", 32'(pass), 32'd1);
        chk("post_rst_err_cnt", 32'(err_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nand_sweep_ctrl.md
Name: nand_sweep_ctrl

Overview:
Synchronous sequencer that exercises a 2-input gate (`nand_gate` by default) through all four input vectors, waits a programmable settle time, and checks the gate output against a latched 4-bit truth table. It accumulates error statistics and reports through a start/busy/done handshake. It sits between a host (bench or self-test logic) and one combinational gate instance: it drives the gate's A/B and samples its Y.

Parameters:
SETTLE_CYCLES, 2, idle cycles between the DRIVE state and the SAMPLE state; 0 is legal.
LOOPS, 1, number of full 4-vector sweeps per run; must be >= 1.
ERR_W, 4, width of err_cnt; the counter saturates at all-ones.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  run request; accepted only in IDLE.
abort  input  1  cancel the current run.
truth  input  4  expected Y per vector, index {A,B}; NAND = 4'b0111; latched when start is accepted.
drive_a  output  1  registered, to gate A.
drive_b  output  1  registered, to gate B.
gate_y  input  1  gate output Y.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse at run completion.
pass  output  1  1 if the last completed run had zero errors.
err_cnt  output  ERR_W  mismatch count for the current or last run.
err_mask  output  4  bit v set if vector v failed at least once.
first_err_vec  output  2  {A,B} of the first mismatch in the run.

Behaviour:
- Reset (rst=1 on an edge): state=IDLE. drive_a, drive_b, busy, done, pass, err_cnt, err_mask and first_err_vec all go to 0. Loop, vector and settle counters go to 0. Reset mid-run aborts silently; no done pulse is produced.
- FSM states: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
- IDLE, start=1 (and abort=0):
  - Go to DRIVE.
  - Latch truth; clear err_cnt, err_mask, first_err_vec and pass.
  - Set vec=0 and loop=0.
  - start=1 in any other state is ignored.
- DRIVE: {drive_a,drive_b} <= vec. Go to SETTLE with counter=SETTLE_CYCLES, or directly to SAMPLE if SETTLE_CYCLES=0.
- SETTLE: decrement the counter each cycle; go to SAMPLE when the counter reaches 1.
- SAMPLE:
  - Compare gate_y with truth_latched[vec].
  - On mismatch:
    - err_cnt increments (holds at max if already saturated).
    - err_mask[vec] is set.
    - first_err_vec <= vec if this is the first mismatch of the run.
  - Then:
    - If vec=3 and loop=LOOPS-1, go to DONE.
    - Else if vec=3, set vec=0, loop++, go to DRIVE.
    - Otherwise vec++, go to DRIVE.
- DONE: done=1 and pass=(err_cnt==0) for exactly this one cycle (pass holds afterwards). Go to IDLE.
- Vector order: 00, 01, 10, 11, repeated LOOPS times.
- Timing: each vector takes SETTLE_CYCLES+2 cycles. done is high in the cycle after the 4·LOOPS·(SETTLE_CYCLES+2)-th rising edge following the edge that accepted start. Example: S=2, L=1 gives 16 edges.
- drive_a and drive_b hold their last vector after DONE until the next DRIVE or reset.
- abort=1 in any non-IDLE state:
  - Next state is IDLE, with no done pulse.
  - drive_a and drive_b go to 0; pass goes to 0.
  - err_cnt, err_mask and first_err_vec keep their values.
- Simultaneous events:
  - rst has priority over abort.
  - abort has priority over start.
  - If abort arrives in SAMPLE, the comparison of that cycle is discarded.
- truth changes after start is accepted have no effect.

Decomposition:
- Shared package `nand_sweep_pkg`:
  - FSM state encoding localparams (IDLE=0, DRIVE=1, SETTLE=2, SAMPLE=3, DONE=4, 3-bit).
  - Truth constants TRUTH_NAND=4'b0111, TRUTH_AND=4'b1000, TRUTH_OR=4'b1110, TRUTH_XOR=4'b0110.
- Sub-module `settle_timer`: load/decrement counter with a terminal flag, parameterised by SETTLE_CYCLES.
- The gate under control is instantiated in the bench, not inside this block.

Test Plan:
1. Hold rst for 2 cycles -> all outputs 0, busy=0. Pulse start during rst -> ignored.
2. truth=0111 with a real nand_gate, S=2, L=1 -> drive sequence 00, 01, 10, 11. done is high in the cycle after the 16th edge; pass=1, err_cnt=0, err_mask=0000.
3. truth=1000 with a real nand_gate -> err_cnt=4, err_mask=1111, first_err_vec=00, pass=0.
4. gate_y stuck at 1, truth=0111, LOOPS=3 -> err_cnt=3, err_mask=1000, first_err_vec=11, pass=0, done after 48 edges.
5. start while busy -> ignored, run length unchanged. abort in SETTLE of vector 2 -> IDLE next cycle, no done, drive lines 0, err stats kept.
6. rst in SAMPLE mid-run -> all outputs reset next cycle. A new start then completes normally with pass=1.
